// File: rtl/alu_exec_unit_if.sv
// Start/Ready/Done handshake bundle between a multicycle datapath controller
// and the ALU execution unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       ALUOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       Shamt;
  logic             ShiftRight;
  logic             Ready;
  logic             Done;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             InvalidOp;

  modport master (
    output Start, ALUOperation, A, B, Shamt, ShiftRight,
    input  Ready, Done, ALUResult, Zero, InvalidOp
  );

  modport slave (
    input  Start, ALUOperation, A, B, Shamt, ShiftRight,
    output Ready, Done, ALUResult, Zero, InvalidOp
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Sequential ALU execution unit: single-cycle logic/arith/LUI ops and
// iterative one-bit-per-cycle logical shifts behind a Start/Ready/Done handshake.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  alu_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_NOR   = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_LUI   = 3'b101;
  localparam logic [2:0] OP_SHIFT = 3'b110;

  function automatic logic [WIDTH-1:0] alu_compute(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [31:0] lui;
    lui = {b[15:0], 16'h0000};
    case (op)
      OP_AND:  alu_compute = a & b;
      OP_OR:   alu_compute = a | b;
      OP_NOR:  alu_compute = ~(a | b);
      OP_ADD:  alu_compute = a + b;
      OP_SUB:  alu_compute = a - b;
      OP_LUI:  alu_compute = lui[WIDTH-1:0];
      default: alu_compute = {WIDTH{1'b0}};
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(
    input logic [WIDTH-1:0] v,
    input logic             right
  );
    if (right) begin
      shift_one = {1'b0, v[WIDTH-1:1]};
    end else begin
      shift_one = {v[WIDTH-2:0], 1'b0};
    end
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] work_s;
  logic [4:0]       cnt_r;
  logic [4:0]       cnt_s;
  logic             right_r;
  logic             right_s;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_s;
  logic             load_s;
  logic             zero_r;
  logic             invalid_r;
  logic             invalid_s;
  logic             ready_r;
  logic             done_r;

  // Next-state and datapath decode; the shift operands are captured at acceptance.
  always_comb begin
    state_s   = state_r;
    work_s    = work_r;
    cnt_s     = cnt_r;
    right_s   = right_r;
    result_s  = result_r;
    load_s    = 1'b0;
    invalid_s = invalid_r;
    case (state_r)
      IDLE: begin
        if (bus.Start) begin
          if (bus.ALUOperation == OP_SHIFT) begin
            work_s    = bus.B;
            cnt_s     = bus.Shamt;
            right_s   = bus.ShiftRight;
            invalid_s = 1'b0;
            if (bus.Shamt == 5'd0) begin
              load_s   = 1'b1;
              result_s = bus.B;
              state_s  = DONE;
            end else begin
              state_s  = SHIFT;
            end
          end else if (bus.ALUOperation == 3'b111) begin
            load_s    = 1'b1;
            result_s  = {WIDTH{1'b0}};
            invalid_s = 1'b1;
            state_s   = DONE;
          end else begin
            load_s    = 1'b1;
            result_s  = alu_compute(bus.ALUOperation, bus.A, bus.B);
            invalid_s = 1'b0;
            state_s   = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        work_s = shift_one(work_r, right_r);
        cnt_s  = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          load_s   = 1'b1;
          result_s = work_s;
          state_s  = DONE;
        end else begin
          state_s  = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift working state; the result only moves when an operation completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_r    <= {WIDTH{1'b0}};
      cnt_r     <= 5'd0;
      right_r   <= 1'b0;
      result_r  <= {WIDTH{1'b0}};
      zero_r    <= 1'b1;
      invalid_r <= 1'b0;
    end else begin
      work_r    <= work_s;
      cnt_r     <= cnt_s;
      right_r   <= right_s;
      invalid_r <= invalid_s;
      if (load_s) begin
        result_r <= result_s;
        zero_r   <= (result_s == {WIDTH{1'b0}});
      end else begin
        result_r <= result_r;
        zero_r   <= zero_r;
      end
    end
  end

  // Handshake flags registered from the next state so they line up with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_s == IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  assign bus.Ready     = ready_r;
  assign bus.Done      = done_r;
  assign bus.ALUResult = result_r;
  assign bus.Zero      = zero_r;
  assign bus.InvalidOp = invalid_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, randomized
// ops against a behavioural model, and handshake/reset corner sequences.
module tb_alu_exec_unit;

  logic clk;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  int   done_run = 0;
  int   done_max = 0;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Track the longest consecutive run of Done cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.Done === 1'b1) done_run++;
      else done_run = 0;
      if (done_run > done_max) done_max = done_run;
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        r;
    logic [31:0] res;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh,
                                        input logic r);
    logic [31:0] lo16;
    lo16 = b & 32'h0000FFFF;
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a | b);
      3'd3:    return a + b;
      3'd4:    return a - b;
      3'd5:    return lo16 * 32'd65536;
      3'd6:    return r ? (b >> sh) : (b << sh);
      default: return 32'd0;
    endcase
  endfunction

  // Issue one op at a negedge, scramble inputs after acceptance, measure latency to Done.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic r, input int poke_at,
                       output int lat);
    int guard;
    guard = 0;
    while (bus.Ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'(bus.Ready), 32'd1);
    bus.Start        = 1'b1;
    bus.ALUOperation = op;
    bus.A            = a;
    bus.B            = b;
    bus.Shamt        = sh;
    bus.ShiftRight   = r;
    @(posedge clk);
    #1;
    bus.Start        = 1'b0;
    bus.ALUOperation = 3'($urandom_range(0, 5));
    bus.A            = $urandom;
    bus.B            = $urandom;
    bus.Shamt        = 5'($urandom);
    bus.ShiftRight   = 1'($urandom);
    @(negedge clk);
    lat = 1;
    while (bus.Done !== 1'b1 && lat < 40) begin
      bus.Start = (lat == poke_at);
      @(negedge clk);
      lat++;
    end
    bus.Start = 1'b0;
  endtask

  int          lat;
  logic [31:0] exp_res;
  int          done_seen;

  initial begin
    bus.Start = 1'b0;
    bus.ALUOperation = 3'b000;
    bus.A = 32'd0;
    bus.B = 32'd0;
    bus.Shamt = 5'd0;
    bus.ShiftRight = 1'b0;
    reset = 1'b1;

    vecs[0]  = '{3'b011, 32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h00000000, 1'b0, 1};
    vecs[1]  = '{3'b100, 32'h00000005, 32'h00000007, 5'd0,  1'b0, 32'hFFFFFFFE, 1'b0, 1};
    vecs[2]  = '{3'b010, 32'h00000000, 32'h00000000, 5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1};
    vecs[3]  = '{3'b101, 32'hABCDEF01, 32'h00001234, 5'd0,  1'b0, 32'h12340000, 1'b0, 1};
    vecs[4]  = '{3'b110, 32'h00000000, 32'h00000001, 5'd31, 1'b0, 32'h80000000, 1'b0, 32};
    vecs[5]  = '{3'b110, 32'h00000000, 32'h80000000, 5'd4,  1'b1, 32'h08000000, 1'b0, 5};
    vecs[6]  = '{3'b110, 32'h00000000, 32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF, 1'b0, 1};
    vecs[7]  = '{3'b000, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0,  1'b0, 32'h00F0F000, 1'b0, 1};
    vecs[8]  = '{3'b001, 32'hF0000000, 32'h0000000F, 5'd0,  1'b0, 32'hF000000F, 1'b0, 1};
    vecs[9]  = '{3'b111, 32'h00000003, 32'h00000004, 5'd0,  1'b0, 32'h00000000, 1'b1, 1};
    vecs[10] = '{3'b011, 32'h00000003, 32'h00000004, 5'd0,  1'b0, 32'h00000007, 1'b0, 1};
    vecs[11] = '{3'b101, 32'h00000000, 32'hFFFF8001, 5'd0,  1'b0, 32'h80010000, 1'b0, 1};

    // Power-on reset, sampled mid-cycle without any clock edge.
    #3;
    check("rst_ready", 32'(bus.Ready), 32'd1);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_result", bus.ALUResult, 32'd0);
    check("rst_zero", 32'(bus.Zero), 32'd1);
    check("rst_invalid", 32'(bus.InvalidOp), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].r, 0, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_result", i), bus.ALUResult, vecs[i].res);
      check($sformatf("vec%0d_zero", i), 32'(bus.Zero), 32'(vecs[i].res == 32'd0));
      check($sformatf("vec%0d_invalid", i), 32'(bus.InvalidOp), 32'(vecs[i].inv));
      check($sformatf("vec%0d_ready_in_done", i), 32'(bus.Ready), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_done_drop", i), 32'(bus.Done), 32'd0);
      check($sformatf("vec%0d_ready_back", i), 32'(bus.Ready), 32'd1);
      check($sformatf("vec%0d_hold", i), bus.ALUResult, vecs[i].res);
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic        r;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 8 == 0) ? a : $urandom;
      sh = 5'($urandom);
      r  = 1'($urandom);
      if (op == 3'd4 && i % 8 == 0) b = a;
      exp_res = model(op, a, b, sh, r);
      do_op(op, a, b, sh, r, 0, lat);
      check($sformatf("rnd%0d_op%0d_latency", i, op), 32'(lat), (op == 3'd6) ? 32'(sh) + 32'd1 : 32'd1);
      check($sformatf("rnd%0d_op%0d_result", i, op), bus.ALUResult, exp_res);
      check($sformatf("rnd%0d_zero", i), 32'(bus.Zero), 32'(exp_res == 32'd0));
      check($sformatf("rnd%0d_invalid", i), 32'(bus.InvalidOp), 32'(op == 3'd7));
      @(negedge clk);
    end

    // Start pulsed mid-shift must be ignored and not queued.
    do_op(3'b110, 32'd0, 32'h00000003, 5'd10, 1'b0, 3, lat);
    check("poke_latency", 32'(lat), 32'd11);
    check("poke_result", bus.ALUResult, 32'h00000C00);
    repeat (3) @(negedge clk);
    check("poke_not_queued_done", 32'(bus.Done), 32'd0);
    check("poke_not_queued_result", bus.ALUResult, 32'h00000C00);

    // Start held high: second acceptance on the edge after Done.
    bus.Start = 1'b1;
    bus.ALUOperation = 3'b011;
    bus.A = 32'd1;
    bus.B = 32'd2;
    @(negedge clk);
    check("held_first_done", 32'(bus.Done), 32'd1);
    check("held_first_result", bus.ALUResult, 32'd3);
    bus.B = 32'd5;
    @(negedge clk);
    check("held_idle_done", 32'(bus.Done), 32'd0);
    check("held_idle_ready", 32'(bus.Ready), 32'd1);
    @(negedge clk);
    check("held_second_done", 32'(bus.Done), 32'd1);
    check("held_second_result", bus.ALUResult, 32'd6);
    bus.Start = 1'b0;
    @(negedge clk);
    check("held_done_drop", 32'(bus.Done), 32'd0);

    // Asynchronous reset during a Done cycle with a nonzero result.
    do_op(3'b010, 32'd0, 32'd0, 5'd0, 1'b0, 0, lat);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_ready", 32'(bus.Ready), 32'd1);
    check("async_rst_done", 32'(bus.Done), 32'd0);
    check("async_rst_result", bus.ALUResult, 32'd0);
    check("async_rst_zero", 32'(bus.Zero), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Invalid op first so the mid-shift reset also shows InvalidOp clearing.
    do_op(3'b111, 32'd3, 32'd4, 5'd0, 1'b0, 0, lat);
    check("inv_before_shift", 32'(bus.InvalidOp), 32'd1);
    @(negedge clk);

    // Reset mid-shift: abandoned, no Done afterwards, next ADD behaves normally.
    bus.Start = 1'b1;
    bus.ALUOperation = 3'b110;
    bus.B = 32'd1;
    bus.Shamt = 5'd20;
    bus.ShiftRight = 1'b0;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midshift_rst_ready", 32'(bus.Ready), 32'd1);
    check("midshift_rst_result", bus.ALUResult, 32'd0);
    check("midshift_rst_zero", 32'(bus.Zero), 32'd1);
    check("midshift_rst_invalid", 32'(bus.InvalidOp), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midshift_ready_first", 32'(bus.Ready), 32'd1);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) done_seen++;
    end
    check("midshift_no_done", 32'(done_seen), 32'd0);
    do_op(3'b011, 32'd3, 32'd4, 5'd0, 1'b0, 0, lat);
    check("post_rst_add_latency", 32'(lat), 32'd1);
    check("post_rst_add_result", bus.ALUResult, 32'd7);
    @(negedge clk);

    check("done_pulse_width", 32'(done_max), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
